// File: rtl/led_sequencer.sv
// 8-LED pattern sequencer: programmable step prescaler, four patterns,
// run/pause/stop control and a 15-level PWM brightness gate on the LED bank.
module led_sequencer #(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [3:0]       cfg_bright,
    input  logic             start,
    input  logic             stop,
    output logic [7:0]       LED,
    output logic             busy,
    output logic             step
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] M_COUNT = 2'd0;
    localparam logic [1:0] M_SCAN  = 2'd1;
    localparam logic [1:0] M_FILL  = 2'd2;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       bright_q, bright_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       pat_q, pat_d;
    logic [7:0]       led_q, led_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             step_q, step_d;

    logic             cfg_accept;
    logic             wrap;
    logic [7:0]       scan_next;
    logic [7:0]       pat_adv;

    function automatic logic [7:0] init_pat(input logic [1:0] m);
        return (m == M_SCAN) ? 8'h01 : 8'h00;
    endfunction

    // Next pattern value for the current mode; dir_q = 1 means shifting right.
    always_comb begin
        scan_next = dir_q ? (pat_q >> 1) : (pat_q << 1);
        case (mode_q)
            M_COUNT: pat_adv = pat_q + 8'd1;
            M_SCAN:  pat_adv = scan_next;
            M_FILL:  pat_adv = (pat_q == 8'hFF) ? 8'h00 : {pat_q[6:0], 1'b1};
            default: pat_adv = ~pat_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        bright_d  = bright_q;
        pat_d     = pat_q;
        dir_d     = dir_q;
        step_d    = 1'b0;

        cfg_accept = cfg_valid && (state_q != S_RUN);
        wrap       = (div_cnt_q == div_q - DIV_W'(1));

        if (state_q == S_RUN) begin
            if (wrap) begin
                div_cnt_d = '0;
                pat_d     = pat_adv;
                step_d    = 1'b1;
                if (mode_q == M_SCAN && (scan_next == 8'h80 || scan_next == 8'h01)) begin
                    dir_d = ~dir_q;
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        if (state_q == S_IDLE) begin
            pwm_cnt_d = 4'd0;
        end else if (pwm_cnt_q == 4'd14) begin
            pwm_cnt_d = 4'd0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + 4'd1;
        end

        if (cfg_accept) begin
            mode_d    = cfg_mode;
            div_d     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            bright_d  = cfg_bright;
            pat_d     = init_pat(cfg_mode);
            div_cnt_d = '0;
            dir_d     = 1'b0;
        end

        // stop has priority over start when both arrive together
        if (stop) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end else if (state_q == S_PAUSE) begin
                state_d = S_IDLE;
            end
        end else if (start && state_q != S_RUN) begin
            state_d = S_RUN;
        end

        if (state_q == S_IDLE && state_d == S_RUN) begin
            pat_d     = init_pat(mode_d);
            div_cnt_d = '0;
            dir_d     = 1'b0;
        end
        if (state_q != S_IDLE && state_d == S_IDLE) begin
            pat_d = 8'h00;
        end

        busy_d = (state_d != S_IDLE);
        led_d  = (state_q == S_IDLE) ? 8'h00 : (pat_q & {8{pwm_cnt_q < bright_q}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= M_COUNT;
            div_q     <= DIV_W'(DEFAULT_DIV);
            div_cnt_q <= '0;
            bright_q  <= 4'd15;
            pwm_cnt_q <= 4'd0;
            pat_q     <= 8'h00;
            led_q     <= 8'h00;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            bright_q  <= bright_d;
            pwm_cnt_q <= pwm_cnt_d;
            pat_q     <= pat_d;
            led_q     <= led_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            step_q    <= step_d;
        end
    end

    assign cfg_ready = (state_q != S_RUN);
    assign LED       = led_q;
    assign busy      = busy_q;
    assign step      = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: step-count reference model checked every cycle,
// directed scenarios with literal pins, then a randomized control/config run.
module tb_led_sequencer;

    localparam int unsigned TB_DEF = 37;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;

    logic        clk;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_div;
    logic [3:0]  cfg_bright;
    logic        start;
    logic        stop;
    logic [7:0]  LED;
    logic        busy;
    logic        step;

    led_sequencer #(.DIV_W(32), .DEFAULT_DIV(TB_DEF)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_div    (cfg_div),
        .cfg_bright (cfg_bright),
        .start      (start),
        .stop       (stop),
        .LED        (LED),
        .busy       (busy),
        .step       (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the pattern is a pure function of how many steps have elapsed
    // since it was last loaded; brightness follows from cycles spent active.
    int         m_st, m_mode, m_bright, m_n, m_pwm;
    longint     m_div, m_phase;
    logic [7:0] m_led;
    logic       m_step;
    int         ff_cnt, on_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pattern(input int mode, input int n);
        int p;
        case (mode)
            0: return 8'(n % 256);
            1: begin
                p = n % 14;
                if (p > 7) p = 14 - p;
                return 8'(1 << p);
            end
            2: return 8'((1 << (n % 9)) - 1);
            default: return (n % 2 == 1) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_st = ST_IDLE; m_mode = 0; m_div = TB_DEF; m_bright = 15;
        m_n = 0; m_phase = 0; m_pwm = 0; m_led = 8'h00; m_step = 1'b0;
    endtask

    task automatic model_edge();
        int nst;
        logic [7:0] nled;
        logic nstep;
        if (!reset_n) begin
            model_reset();
            return;
        end
        nled  = (m_st == ST_IDLE) ? 8'h00 :
                ((m_pwm < m_bright) ? pattern(m_mode, m_n) : 8'h00);
        nstep = 1'b0;
        if (m_st == ST_RUN) begin
            if (m_phase == m_div - 1) begin
                m_phase = 0; m_n++; nstep = 1'b1;
            end else begin
                m_phase++;
            end
        end
        m_pwm = (m_st == ST_IDLE) ? 0 : (m_pwm + 1) % 15;
        if (cfg_valid && m_st != ST_RUN) begin
            m_mode = int'(cfg_mode);
            m_div = (cfg_div == 0) ? 1 : longint'(cfg_div);
            m_bright = int'(cfg_bright);
            m_n = 0; m_phase = 0;
        end
        nst = m_st;
        if (stop) begin
            if (m_st == ST_RUN) nst = ST_PAUSE;
            else if (m_st == ST_PAUSE) nst = ST_IDLE;
        end else if (start && m_st != ST_RUN) begin
            nst = ST_RUN;
        end
        if (m_st == ST_IDLE && nst == ST_RUN) begin
            m_n = 0; m_phase = 0;
        end
        m_st = nst; m_led = nled; m_step = nstep;
    endtask

    task automatic compare_all();
        chk("led", {24'd0, LED}, {24'd0, m_led});
        chk("busy", {31'd0, busy}, {31'd0, m_st != ST_IDLE});
        chk("step", {31'd0, step}, {31'd0, m_step});
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, m_st != ST_RUN});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic configure(input logic [1:0] m, input logic [31:0] d, input logic [3:0] b);
        cfg_valid = 1'b1; cfg_mode = m; cfg_div = d; cfg_bright = b;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_div = 32'd0;
        cfg_bright = 4'd0; start = 1'b0; stop = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_led", {24'd0, LED}, 32'h00);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        reset_n = 1'b1;
        tick();

        // COUNT, div 4
        configure(2'd0, 32'd4, 4'd15);
        pulse_start();
        for (int i = 1; i <= 1030; i++) begin
            tick();
            if (i == 4)    chk("count_step_i4", {31'd0, step}, 32'd1);
            if (i == 5)    chk("count_step_i5", {31'd0, step}, 32'd0);
            if (i == 5)    chk("count_led_01", {24'd0, LED}, 32'h01);
            if (i == 1021) chk("count_led_ff", {24'd0, LED}, 32'hFF);
            if (i == 1025) chk("count_led_wrap", {24'd0, LED}, 32'h00);
        end

        // SCAN, div 1
        pulse_stop(); pulse_stop();
        configure(2'd1, 32'd1, 4'd15);
        pulse_start();
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("scan_step", {31'd0, step}, 32'd1);
            if (i == 1)  chk("scan_led_01", {24'd0, LED}, 32'h01);
            if (i == 8)  chk("scan_led_80", {24'd0, LED}, 32'h80);
            if (i == 9)  chk("scan_led_40", {24'd0, LED}, 32'h40);
            if (i == 15) chk("scan_led_back01", {24'd0, LED}, 32'h01);
            if (i == 16) chk("scan_led_02", {24'd0, LED}, 32'h02);
        end

        // FILL, div 2, pause mid-period then resume
        pulse_stop(); pulse_stop();
        configure(2'd2, 32'd2, 4'd15);
        pulse_start();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 3)  chk("fill_led_01", {24'd0, LED}, 32'h01);
            if (i == 17) chk("fill_led_ff", {24'd0, LED}, 32'hFF);
            if (i == 19) chk("fill_led_00", {24'd0, LED}, 32'h00);
        end
        pulse_stop();
        repeat (6) tick();
        chk("pause_busy", {31'd0, busy}, 32'd1);
        chk("pause_ready", {31'd0, cfg_ready}, 32'd1);
        pulse_start();
        repeat (24) tick();

        // BLINK, bright 5, div 30
        pulse_stop(); pulse_stop();
        configure(2'd3, 32'd30, 4'd5);
        pulse_start();
        ff_cnt = 0;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (i >= 31 && i <= 60 && LED == 8'hFF) ff_cnt++;
        end
        chk("blink_on_cycles", ff_cnt, 32'd10);
        pulse_stop();
        configure(2'd3, 32'd30, 4'd0);
        pulse_start();
        on_cnt = 0;
        for (int i = 1; i <= 90; i++) begin
            tick();
            if (LED != 8'h00) on_cnt++;
        end
        chk("bright0_dark", on_cnt, 32'd0);

        // config request held during RUN, accepted once paused
        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_div = 32'd3; cfg_bright = 4'd15;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("run_ready_low", {31'd0, cfg_ready}, 32'd0);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        cfg_valid = 1'b0;
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("startstop_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("startstop_led", {24'd0, LED}, 32'h00);

        // asynchronous reset mid-run
        pulse_start();
        repeat (20) tick();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_led", {24'd0, LED}, 32'h00);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, cfg_ready}, 32'd1);
        compare_all();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        pulse_start();
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 36) chk("def_div_nostep", {31'd0, step}, 32'd0);
            if (i == 37) chk("def_div_step", {31'd0, step}, 32'd1);
            if (i == 38) chk("def_mode_led", {24'd0, LED}, 32'h01);
        end

        // randomized control and configuration
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 99) < 5);
            stop       = ($urandom_range(0, 99) < 4);
            cfg_valid  = ($urandom_range(0, 99) < 10);
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_div    = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 5));
            cfg_bright = 4'($urandom_range(0, 15));
            tick();
        end
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
